// File: rtl/bm_stream_checker_if.sv
`timescale 1ns/1ps
// Sample stream and golden-memory bus between a stream source and the checker.
// The master side supplies samples and golden data; the slave side (the
// checker) consumes them and drives the golden-memory read address.
interface bm_stream_checker_if #(
  parameter int W   = 16,
  parameter int NCH = 2,
  parameter int AW  = 18
);
  logic              sample_valid;
  logic [NCH*W-1:0]  sample_data;
  logic [AW-1:0]     rom_addr;
  logic [NCH*W-1:0]  rom_data;

  modport master (
    output sample_valid,
    output sample_data,
    output rom_data,
    input  rom_addr
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  rom_data,
    output rom_addr
  );
endinterface

// File: rtl/bm_stream_checker.sv
`timescale 1ns/1ps
// Stream checker: compares an incoming sample stream against a golden memory,
// channel by channel, and reports sticky flags, saturating error counts and
// the location of the first failure.
module bm_stream_checker #(
  parameter  int W   = 16,
  parameter  int NCH = 2,
  parameter  int AW  = 18,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [AW-1:0]      num_samples,
  input  logic [NCH-1:0]     ch_en,
  bm_stream_checker_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NCH-1:0]     mismatch,
  output logic [NCH-1:0]     err_flag,
  output logic [NCH*16-1:0]  err_count,
  output logic [AW-1:0]      first_err_addr,
  output logic [CHW-1:0]     first_err_ch,
  output logic               first_err_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, num_q, smp_idx_q;
  logic [NCH-1:0]      en_q;
  logic [NCH*W-1:0]    smp_q;
  logic                cmp_v_q;
  logic [NCH-1:0]      mismatch_q, err_flag_q;
  logic [NCH*16-1:0]   err_count_q;
  logic [AW-1:0]       first_addr_q;
  logic [CHW-1:0]      first_ch_q;
  logic                first_v_q;

  logic                start_ok, accept, last_accept;
  logic [NCH-1:0]      fail_vec;
  logic [CHW-1:0]      fail_ch;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort has priority over everything, including start.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely
    // combinational; a missed path would otherwise infer a latch.
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = (num_samples == '0) ? S_DONE : S_RUN;
        S_RUN:          if (last_accept) state_d = S_DRAIN;
        S_DRAIN:        state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and per-cycle control strobes.
  always_comb begin
    busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
    pass        = done && (err_flag_q == '0);
    start_ok    = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    accept      = (state_q == S_RUN) && bus.sample_valid && !abort;
    last_accept = accept && ((idx_q + AW'(1)) == num_q);
  end

  // Compare the registered sample against golden data; lowest failing channel wins.
  always_comb begin
    fail_vec = '0;
    fail_ch  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cmp_v_q && !abort && en_q[k] && (smp_q[k*W +: W] != bus.rom_data[k*W +: W])) begin
        fail_vec[k] = 1'b1;
        fail_ch     = CHW'(k);
      end
    end
  end

  // Datapath: sample capture, index advance, result accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      num_q        <= '0;
      en_q         <= '0;
      smp_q        <= '0;
      smp_idx_q    <= '0;
      cmp_v_q      <= 1'b0;
      mismatch_q   <= '0;
      err_flag_q   <= '0;
      err_count_q  <= '0;
      first_addr_q <= '0;
      first_ch_q   <= '0;
      first_v_q    <= 1'b0;
    end else begin
      mismatch_q <= fail_vec;
      cmp_v_q    <= accept;
      if (accept) begin
        smp_q     <= bus.sample_data;
        smp_idx_q <= idx_q;
        idx_q     <= idx_q + AW'(1);
      end
      if (start_ok) begin
        idx_q        <= '0;
        num_q        <= num_samples;
        en_q         <= ch_en;
        err_flag_q   <= '0;
        err_count_q  <= '0;
        first_addr_q <= '0;
        first_ch_q   <= '0;
        first_v_q    <= 1'b0;
      end else if (fail_vec != '0) begin
        err_flag_q <= err_flag_q | fail_vec;
        for (int k = 0; k < NCH; k++) begin
          if (fail_vec[k] && (err_count_q[k*16 +: 16] != 16'hFFFF))
            err_count_q[k*16 +: 16] <= err_count_q[k*16 +: 16] + 16'd1;
        end
        if (!first_v_q) begin
          first_addr_q <= smp_idx_q;
          first_ch_q   <= fail_ch;
          first_v_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.rom_addr    = idx_q;
  assign mismatch        = mismatch_q;
  assign err_flag        = err_flag_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_addr_q;
  assign first_err_ch    = first_ch_q;
  assign first_err_valid = first_v_q;

endmodule
